// File: rtl/irq_grant_decoder_pkg.sv
// Shared types and constants for the interrupt grant decoder.
// Optional feature macro: IRQ_ACK_TIMEOUT_EN (ACK-state timeout).
package irq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ACK,
        ERR,
        GAP
    } state_t;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_BUS  = 3'd1;
    localparam logic [2:0] ERR_CHAN = 3'd2;
    localparam logic [2:0] ERR_SPUR = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;

    localparam int NUM_BUS_DEF  = 3;
    localparam int NUM_CHAN_DEF = 9;

    // Width needed to address every request line (bus*NUM_CHAN + chan).
    function automatic int idx_width(input int nb, input int nc);
        return (nb * nc > 1) ? $clog2(nb * nc) : 1;
    endfunction

endpackage

// File: rtl/irq_grant_decoder_if.sv
// Grant handshake plus request/acknowledge lines between the priority
// encoder / requesters (master) and the grant decoder (slave).
interface irq_grant_decoder_if
    import irq_pkg::*;
#(
    parameter int NUM_BUS  = NUM_BUS_DEF,
    parameter int NUM_CHAN = NUM_CHAN_DEF
) ();

    logic                         gnt_vld;
    logic                         gnt_rdy;
    logic [NUM_BUS-1:0]           gnt_bus;
    logic [3:0]                   gnt_chan;
    logic [NUM_BUS*NUM_CHAN-1:0]  req;
    logic [NUM_BUS*NUM_CHAN-1:0]  ack;

    modport master (
        output gnt_vld, gnt_bus, gnt_chan, req,
        input  gnt_rdy, ack
    );

    modport slave (
        input  gnt_vld, gnt_bus, gnt_chan, req,
        output gnt_rdy, ack
    );

endinterface

// File: rtl/irq_grant_decoder_check.sv
// Combinational validation of a captured grant: one-hot bus check,
// channel range check and flat request index computation.
module irq_grant_check
    import irq_pkg::*;
#(
    parameter int NUM_BUS  = NUM_BUS_DEF,
    parameter int NUM_CHAN = NUM_CHAN_DEF,
    parameter int IW       = idx_width(NUM_BUS_DEF, NUM_CHAN_DEF)
) (
    input  logic [NUM_BUS-1:0] bus_i,
    input  logic [3:0]         chan_i,
    output logic               bus_ok_o,
    output logic               chan_ok_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW-1:0] bus_num;

    // One-hot test, bus number encode and index arithmetic.
    always_comb begin
        bus_ok_o  = (bus_i != '0) && ((bus_i & (bus_i - 1'b1)) == '0);
        chan_ok_o = (int'(chan_i) < NUM_CHAN);
        bus_num   = '0;
        for (int unsigned i = 0; i < NUM_BUS; i++) begin
            if (bus_i[i]) begin
                bus_num = IW'(i);
            end
        end
        idx_o = IW'(int'(bus_num) * NUM_CHAN + int'(chan_i));
    end

endmodule

// File: rtl/irq_grant_decoder.sv
// Grant decoder: accepts an encoder grant, validates it, drives a one-hot
// acknowledge and runs a four-phase req/ack handshake, counting completions.
// Optional feature macro: IRQ_ACK_TIMEOUT_EN (abandon ACK after TIMEOUT cycles).
module irq_grant_decoder
    import irq_pkg::*;
#(
    parameter int NUM_BUS  = NUM_BUS_DEF,
    parameter int NUM_CHAN = NUM_CHAN_DEF,
    parameter int ACK_GAP  = 2,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic              CLK,
    input  logic              RST,
    irq_grant_decoder_if.slave gnt,
    output logic              busy,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  served_cnt
);

    localparam int NREQ  = NUM_BUS * NUM_CHAN;
    localparam int IW    = idx_width(NUM_BUS, NUM_CHAN);
    localparam int GAP_W = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;

    state_t             state_q, state_d;
    logic [NUM_BUS-1:0] bus_q, bus_d;
    logic [3:0]         chan_q, chan_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [2:0]         code_q, code_d;
    logic [NREQ-1:0]    ack_q, ack_d;

    logic               bus_ok;
    logic               chan_ok;
    logic [IW-1:0]      chk_idx;

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

    irq_grant_check #(
        .NUM_BUS  (NUM_BUS),
        .NUM_CHAN (NUM_CHAN),
        .IW       (IW)
    ) u_check (
        .bus_i     (bus_q),
        .chan_i    (chan_q),
        .bus_ok_o  (bus_ok),
        .chan_ok_o (chan_ok),
        .idx_o     (chk_idx)
    );

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            bus_q   <= '0;
            chan_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            ack_q   <= '0;
`ifdef IRQ_ACK_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            chan_q  <= chan_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ack_q   <= ack_d;
`ifdef IRQ_ACK_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so that
    // ready, busy and ack change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        chan_d  = chan_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
`ifdef IRQ_ACK_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                if (gnt.gnt_vld && rdy_q) begin
                    bus_d   = gnt.gnt_bus;
                    chan_d  = gnt.gnt_chan;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!bus_ok) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_BUS;
                end else if (!chan_ok) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_CHAN;
                end else if (!gnt.req[chk_idx]) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_SPUR;
                end else begin
                    state_d = ACK;
                    idx_d   = chk_idx;
`ifdef IRQ_ACK_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            ACK: begin
                if (!gnt.req[idx_q]) begin
                    state_d = GAP;
                    gap_d   = '0;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
`ifdef IRQ_ACK_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
`endif
            end
            GAP: begin
                if (gap_q == GAP_W'(ACK_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d   = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        ack_d  = '0;
        if (state_d == ACK) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                ack_d[i] = (IW'(i) == idx_d);
            end
        end
    end

    assign gnt.gnt_rdy = rdy_q;
    assign gnt.ack     = ack_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign served_cnt  = cnt_q;

endmodule

// File: tb/tb_irq_grant_decoder.sv
// Directed self-checking bench for irq_grant_decoder.
// Honours IRQ_ACK_TIMEOUT_EN when the macro is defined for the build.
module tb_irq_grant_decoder;
    import irq_pkg::*;

    localparam int NB    = 3;
    localparam int NC    = 9;
    localparam int GAPC  = 2;
    localparam int CW    = 2;
    localparam int TMO   = 64;
    localparam int NR    = NB * NC;

    logic          CLK;
    logic          RST;
    logic          busy;
    logic          err;
    logic [2:0]    err_code;
    logic [CW-1:0] served_cnt;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int exp_cnt  = 0;

    irq_grant_decoder_if #(.NUM_BUS(NB), .NUM_CHAN(NC)) gif ();

    irq_grant_decoder #(
        .NUM_BUS  (NB),
        .NUM_CHAN (NC),
        .ACK_GAP  (GAPC),
        .CNT_W    (CW),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .gnt        (gif),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .served_cnt (served_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count accepted grants as seen on the bus.
    always @(posedge CLK) begin
        if (!RST && gif.gnt_vld && gif.gnt_rdy) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic grant(input logic [NB-1:0] b, input logic [3:0] c);
        gif.gnt_bus  = b;
        gif.gnt_chan = c;
        gif.gnt_vld  = 1'b1;
        tick();
        gif.gnt_vld  = 1'b0;
    endtask

    function automatic logic [63:0] bit_at(input int i);
        logic [63:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int waited;
        int acc_base;

        RST          = 1'b1;
        gif.gnt_vld  = 1'b0;
        gif.gnt_bus  = '0;
        gif.gnt_chan = '0;
        gif.req      = '0;

        // Reset state
        tick();
        tick();
        check("rst_ack",  64'(gif.ack), 64'd0);
        check("rst_rdy",  64'(gif.gnt_rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err",  64'(err), 64'd0);
        check("rst_code", 64'(err_code), 64'd0);
        check("rst_cnt",  64'(served_cnt), 64'd0);
        RST = 1'b0;
        tick();
        check("rdy_after_rst", 64'(gif.gnt_rdy), 64'd1);

        // Normal handshake on bus A, channel 4
        gif.req[4] = 1'b1;
        grant(3'b001, 4'd4);
        check("acc_rdy_low", 64'(gif.gnt_rdy), 64'd0);
        check("acc_busy",    64'(busy), 64'd1);
        check("dec_ack0",    64'(gif.ack), 64'd0);
        tick();
        check("ack4_high", 64'(gif.ack), bit_at(4));
        tick();
        check("ack4_hold", 64'(gif.ack), bit_at(4));
        gif.req[4] = 1'b0;
        tick();
        check("ack4_low", 64'(gif.ack), 64'd0);
        exp_cnt = 1;
        check("cnt_1",    64'(served_cnt), 64'(exp_cnt));
        tick();
        check("gap_rdy_low", 64'(gif.gnt_rdy), 64'd0);
        tick();
        check("gap_rdy_high", 64'(gif.gnt_rdy), 64'd1);
        check("idle_busy",    64'(busy), 64'd0);

        // Bad bus select
        grant(3'b011, 4'd0);
        tick();
        check("bus_err",  64'(err), 64'd1);
        check("bus_code", 64'(err_code), 64'(ERR_BUS));
        check("bus_ack",  64'(gif.ack), 64'd0);
        tick();
        check("bus_err_pulse", 64'(err), 64'd0);
        check("bus_rdy",       64'(gif.gnt_rdy), 64'd1);

        // Channel out of range
        grant(3'b100, 4'd9);
        tick();
        check("chan_err",  64'(err), 64'd1);
        check("chan_code", 64'(err_code), 64'(ERR_CHAN));
        tick();

        // Spurious request
        grant(3'b010, 4'd8);
        tick();
        check("spur_code", 64'(err_code), 64'(ERR_SPUR));
        check("spur_ack",  64'(gif.ack), 64'd0);
        tick();
        check("spur_cnt",  64'(served_cnt), 64'(exp_cnt));

        // Highest legal index: bus C, channel 8
        gif.req[26] = 1'b1;
        grant(3'b100, 4'd8);
        tick();
        check("ack26_high", 64'(gif.ack), bit_at(26));
        gif.req[26] = 1'b0;
        tick();
        check("ack26_low", 64'(gif.ack), 64'd0);
        exp_cnt = 2;
        check("cnt_2", 64'(served_cnt), 64'(exp_cnt));
        tick();
        tick();

        // Reset in the middle of a handshake
        gif.req[22] = 1'b1;
        grant(3'b100, 4'd4);
        tick();
        check("ack22_high", 64'(gif.ack), bit_at(22));
        RST = 1'b1;
        #1;
        check("mid_rst_ack",  64'(gif.ack), 64'd0);
        check("mid_rst_cnt",  64'(served_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        gif.req[22] = 1'b0;
        tick();
        check("mid_rst_rdy", 64'(gif.gnt_rdy), 64'd0);
        RST = 1'b0;
        exp_cnt = 0;
        tick();
        check("rdy_after_mid_rst", 64'(gif.gnt_rdy), 64'd1);

        // Requester never releases
        gif.req[0] = 1'b1;
        grant(3'b001, 4'd0);
        tick();
        check("ack0_high", 64'(gif.ack), bit_at(0));
`ifdef IRQ_ACK_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check("tmo_ack_still", 64'(gif.ack), bit_at(0));
        tick();
        check("tmo_ack_low", 64'(gif.ack), 64'd0);
        check("tmo_err",     64'(err), 64'd1);
        check("tmo_code",    64'(err_code), 64'(ERR_TMO));
        check("tmo_cnt",     64'(served_cnt), 64'(exp_cnt));
        gif.req[0] = 1'b0;
        tick();
        tick();
        check("tmo_rdy", 64'(gif.gnt_rdy), 64'd1);
`else
        repeat (1000) tick();
        check("no_tmo_ack", 64'(gif.ack), bit_at(0));
        check("no_tmo_err", 64'(err), 64'd0);
        gif.req[0] = 1'b0;
        tick();
        check("no_tmo_ack_low", 64'(gif.ack), 64'd0);
        exp_cnt = 1;
        check("no_tmo_cnt", 64'(served_cnt), 64'(exp_cnt));
        tick();
        tick();
        check("no_tmo_rdy", 64'(gif.gnt_rdy), 64'd1);
`endif

        // Back-to-back grants with valid held high; counter saturates
        acc_base     = acc_cnt;
        gif.req[12]  = 1'b1;
        gif.gnt_bus  = 3'b010;
        gif.gnt_chan = 4'd3;
        gif.gnt_vld  = 1'b1;
        for (int h = 0; h < 4; h++) begin
            waited = 0;
            while (gif.ack != NR'(bit_at(12)) && waited < 10) begin
                tick();
                waited++;
            end
            check("b2b_ack_high", 64'(gif.ack), bit_at(12));
            tick();
            gif.req[12] = 1'b0;
            tick();
            check("b2b_ack_low", 64'(gif.ack), 64'd0);
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            check("b2b_cnt", 64'(served_cnt), 64'(exp_cnt));
            if (h == 3) begin
                gif.gnt_vld = 1'b0;
            end else begin
                gif.req[12] = 1'b1;
            end
        end
        repeat (5) tick();
        check("b2b_accepts", 64'(acc_cnt - acc_base), 64'd4);
        check("sat_cnt",     64'(served_cnt), 64'd3);
        check("b2b_err",     64'(err), 64'd0);
        check("b2b_idle",    64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
